// File: rtl/vector_serializer.sv
// Vector-to-element serializer: buffers up to DEPTH whole N-element vectors from a
// non-stallable producer and streams them out one element per cycle on valid/ready.
module vector_serializer #(
    parameter int BITS  = 16,
    parameter int N     = 3,
    parameter int DEPTH = 4,
    localparam int IW   = (N > 1) ? $clog2(N) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data [N],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic [IW-1:0]   out_index,
    output logic            out_last,
    output logic [CW-1:0]   level,
    output logic            overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_reg;
    logic [BITS-1:0] mem_reg [DEPTH][N];
    logic [PW-1:0]   wp_reg;
    logic [PW-1:0]   rp_reg;
    logic [IW-1:0]   idx_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            overflow_reg;

    logic            xfer;
    logic            pop;
    logic            push;
    logic            drop;
    logic [DEPTH-1:0] wr_en;

    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    always_comb begin
        xfer       = (state_reg == STREAM) && out_ready;
        pop        = xfer && (idx_reg == LAST_IDX);
        push       = in_valid && ((count_reg != FULL) || pop);
        drop       = in_valid && !push;
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wp_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int j = 0; j < N; j++) begin
                    mem_reg[e][j] <= '0;
                end
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_en[e]) begin
                    for (int j = 0; j < N; j++) begin
                        mem_reg[e][j] <= in_data[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= EMPTY;
            wp_reg       <= '0;
            rp_reg       <= '0;
            idx_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wp_reg <= (wp_reg == LAST_PTR) ? '0 : wp_reg + PW'(1);
            end
            if (pop) begin
                rp_reg <= (rp_reg == LAST_PTR) ? '0 : rp_reg + PW'(1);
            end
            if (xfer) begin
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IW'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            count_reg <= count_next;
            case (state_reg)
                EMPTY:   if (push) state_reg <= STREAM;
                STREAM:  if (count_next == '0) state_reg <= EMPTY;
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state_reg == STREAM);
    assign out_data  = mem_reg[rp_reg][idx_reg];
    assign out_index = idx_reg;
    assign out_last  = (idx_reg == LAST_IDX);
    assign level     = count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_vector_serializer.sv
// Randomized bench for vector_serializer: a queue-of-vectors reference model is
// compared against the DUT every cycle, and emitted streams against expected order.
module tb_vector_serializer;

    localparam int BITS  = 16;
    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [N-1:0][BITS-1:0] vec_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    vec_t            cur_vec = '0;
    logic [BITS-1:0] in_data [N];
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic [CW-1:0]   level;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: stored vectors in arrival order, position within the head.
    vec_t            mq[$];
    int              mpos = 0;
    bit              movf = 1'b0;
    logic [BITS-1:0] rx_q[$];
    logic [BITS-1:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_in
        assign in_data[gi] = cur_vec[gi];
    end

    vector_serializer #(.BITS(BITS), .N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .level     (level),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit xfer;
        bit pop_v;
        bit push_v;
        xfer   = (mq.size() > 0) && out_ready;
        pop_v  = xfer && (mpos == N - 1);
        push_v = in_valid && ((mq.size() < DEPTH) || pop_v);
        if (in_valid && !push_v) movf = 1'b1;
        if (xfer) mpos = pop_v ? 0 : mpos + 1;
        if (pop_v) void'(mq.pop_front());
        if (push_v) mq.push_back(cur_vec);
    endfunction

    task automatic cycle();
        @(negedge clk);
        check("valid", out_valid, (mq.size() > 0));
        check("level", level, mq.size());
        check("overflow", overflow, movf);
        check("index", out_index, mpos);
        check("last", out_last, (mpos == N - 1));
        if (mq.size() > 0) check("data", out_data, mq[0][mpos]);
        if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            $display("xfer data=%h idx=%0d last=%0b level=%0d", out_data, out_index, out_last, level);
        end
        model_step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = BITS'($urandom);
        return v;
    endfunction

    function automatic void expect_vec(input vec_t v);
        for (int j = 0; j < N; j++) exp_q.push_back(v[j]);
    endfunction

    task automatic push_cycle(input vec_t v);
        cur_vec  = v;
        in_valid = 1'b1;
        $display("push e0=%h level=%0d", v[0], level);
        cycle();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 200 && mq.size() > 0; k++) cycle();
        cycle();
        check("drain_level", level, 0);
        check("drain_valid", out_valid, 0);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_elem"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_dut();
        #2 rstn = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_index", out_index, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, (N == 1));
        mq.delete();
        mpos = 0;
        movf = 1'b0;
        rx_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int sent;

        // Power-on reset
        #3;
        check("por_valid", out_valid, 0);
        check("por_level", level, 0);
        check("por_overflow", overflow, 0);
        check("por_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single vector, consumer always ready
        v[0] = 16'h3C00; v[1] = 16'h4000; v[2] = 16'h4200;
        out_ready = 1'b1;
        expect_vec(v);
        push_cycle(v);
        check("single_first", out_data, 16'h3C00);
        drain();
        compare_stream("single");

        // Backpressure: output must hold while out_ready is low
        out_ready = 1'b0;
        expect_vec(v);
        push_cycle(v);
        repeat (5) cycle();
        check("stall_data", out_data, 16'h3C00);
        check("stall_valid", out_valid, 1);
        check("stall_level", level, 1);
        drain();
        compare_stream("stall");

        // Fill and overflow: the fifth vector is dropped
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            v = rand_vec();
            if (k < DEPTH) expect_vec(v);
            push_cycle(v);
        end
        check("full_level", level, DEPTH);
        check("full_overflow", overflow, 1);
        drain();
        check("ovf_sticky", overflow, 1);
        compare_stream("fill");
        reset_dut();

        // Push while full, in the same cycle the head's last element leaves
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            v = rand_vec();
            expect_vec(v);
            push_cycle(v);
        end
        out_ready = 1'b1;
        repeat (N - 1) cycle();
        v = rand_vec();
        expect_vec(v);
        push_cycle(v);
        check("pushpop_overflow", overflow, 0);
        check("pushpop_level", level, DEPTH);
        drain();
        compare_stream("pushpop");

        // Pointer wrap with random backpressure
        sent = 0;
        for (int c = 0; c < 2000 && sent < 10; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                v = rand_vec();
                v[0] = BITS'(sent + 1);
                expect_vec(v);
                sent++;
                push_cycle(v);
            end else begin
                cycle();
            end
        end
        check("wrap_sent", sent, 10);
        drain();
        check("wrap_overflow", overflow, 0);
        compare_stream("wrap");

        // Reset in the middle of a vector
        out_ready = 1'b1;
        v = rand_vec();
        push_cycle(v);
        cycle();
        check("mid_index", out_index, 1);
        check("mid_data", out_data, v[1]);
        reset_dut();
        v = rand_vec();
        expect_vec(v);
        push_cycle(v);
        check("post_rst_index", out_index, 0);
        check("post_rst_data", out_data, v[0]);
        drain();
        compare_stream("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_serializer.md
# vector_serializer

Buffers the N-element result vectors produced by the vector divide stage and emits them one element per cycle on a valid/ready stream. The divide stage has no backpressure, so this block absorbs bursts of up to DEPTH whole vectors and flags any vector it cannot accept. It sits directly downstream of the vector divider and feeds scalar consumers such as a result writer or a UART formatter.

## Interface
- BITS, 16, width of one element (HALF precision by default)
- N, 3, elements per vector; N >= 1
- DEPTH, 4, number of whole vectors stored; DEPTH >= 2, any value (not limited to powers of two)
- IW, derived, max(1, $clog2(N)), index width
- CW, derived, $clog2(DEPTH+1), level width
- clk  input  1  clock; all state updates on the rising edge
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  one-cycle strobe: in_data holds a complete vector
- in_data  input  BITS x [N]  unpacked array of vector elements, element 0 first
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts the element this cycle
- out_data  output  BITS  current element
- out_index  output  IW  element position within its vector, 0..N-1
- out_last  output  1  high when out_index == N-1
- level  output  CW  number of vectors stored, including a partly emitted one
- overflow  output  1  sticky: a vector was dropped

## Operation
- Storage: DEPTH entries of N x BITS registers, write pointer wp, read pointer rp, element index idx, count. Pointers advance from DEPTH-1 back to 0.
- Two states: EMPTY (count == 0, out_valid = 0) and STREAM (count > 0, out_valid = 1). There are no other states. out_valid is a registered function of count and never depends combinationally on out_ready.
- Output mux: out_data = mem[rp][idx], out_index = idx, out_last = (idx == N-1), level = count.
- Transfer: when out_valid && out_ready, idx increments. When a transfer has out_last = 1, idx returns to 0, rp advances, and the entry is freed (pop).
- Write: if in_valid and (count < DEPTH or a pop occurs in the same cycle), in_data is stored at wp and wp advances (push).
- Drop: if in_valid, count == DEPTH, and no pop occurs this cycle, the vector is discarded. overflow is set and stays 1 until reset. No other state changes.
- Simultaneous push and pop: count is unchanged, and rp and wp both advance.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- N == 1: every transfer is last, and idx stays 0.
- Reset, at any time including mid-vector: count = 0, wp = rp = idx = 0, overflow = 0, and all storage is cleared to 0. Partly emitted and buffered vectors are lost. Outputs after reset: out_valid 0, out_data 0, out_index 0, out_last (N == 1), level 0, overflow 0.

## Timing
- Latency: an in_valid sampled at edge t into an empty buffer gives out_valid = 1 and element 0 on out_data after edge t; the consumer sees it in cycle t+1.
- Throughput: one element per cycle while out_ready = 1. Sustained input rate is at most one vector per N cycles.
- Ordering: vectors leave in arrival order, and elements within a vector leave in order 0..N-1.
- level updates on the same edge as the push or pop that changes it.
- overflow rises on the edge that samples the dropped in_valid.
- rstn assertion clears all outputs immediately (asynchronous). Deassertion is synchronized externally; the first push is possible on the first edge after release.

## Test plan
- Single vector: N=3, push {0x3C00,0x4000,0x4200}, out_ready=1 -> next three cycles emit 0x3C00/idx0, 0x4000/idx1, 0x4200/idx2 with out_last=1, then out_valid=0 and level=0.
- Backpressure: push one vector and hold out_ready=0 for 5 cycles -> out_valid=1 and out_data=0x3C00 stable throughout, level=1. Then raise out_ready -> all three elements emitted unchanged.
- Fill and overflow: DEPTH=4, out_ready=0, five pushes one cycle apart -> level=4 and overflow=1 after the 5th. Drain -> exactly 4 vectors in order, and the 5th never appears.
- Push on full with pop: DEPTH=4 full, out_ready=1, and push exactly in the cycle the head's last element transfers -> overflow stays 0 and level stays 4. The new vector emerges last, after the other three buffered vectors.
- Pointer wrap: 10 vectors with values 0x0001..0x000A in element 0, random out_ready at 50% -> all 10 received in order, overflow=0, and level returns to 0.
- Reset mid-vector: assert rstn=0 after idx=1 of a buffered vector -> out_valid, level, out_index and overflow are 0 at once. After release, a new push emits from idx 0.
